// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - handshake bundle between N producers, the mux and one consumer
interface stream_mux_rr_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        i_valid;
  logic [NUM_CH*DATA_W-1:0] i_data;
  logic [NUM_CH-1:0]        i_last;
  logic [NUM_CH-1:0]        o_ready;
  logic                     o_valid;
  logic [DATA_W-1:0]        o_data;
  logic                     o_last;
  logic [CH_W-1:0]          o_ch;
  logic                     i_ready;

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_last, o_ch
  );

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - packet-aware round-robin N:1 stream mux with one registered output stage
// Optional forced-channel select is enabled by defining STREAM_MUX_FORCE_SEL_EN.
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
`ifdef STREAM_MUX_FORCE_SEL_EN
  input  logic            i_force,
  input  logic [CH_W-1:0] i_force_ch,
`endif
  stream_mux_rr_if.slave  bus
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  localparam logic [CH_W:0] NUM_CH_X = (CH_W+1)'(NUM_CH);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic              o_valid_q, o_valid_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic              o_last_q, o_last_d;
  logic [CH_W-1:0]   o_ch_q, o_ch_d;

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] rdy;
  logic              out_free;
  logic              gnt_en;
  logic [CH_W-1:0]   gnt_ch;
  logic              xfer;
  logic [CH_W:0]     cand;
  logic [CH_W:0]     nxt_ch;

  assign out_free = !o_valid_q || bus.i_ready;

  always_comb begin
    elig = bus.i_valid;
`ifdef STREAM_MUX_FORCE_SEL_EN
    // A forced select narrows eligibility to one channel; out-of-range grants nothing.
    if (i_force) begin
      elig = '0;
      if ({1'b0, i_force_ch} < NUM_CH_X) begin
        elig[i_force_ch] = bus.i_valid[i_force_ch];
      end
    end
`endif
  end

  // Scan from the far end toward ptr so the closest eligible channel is the last to write.
  always_comb begin
    gnt_en = 1'b0;
    gnt_ch = '0;
    cand   = '0;
    if (state_q == S_LOCKED) begin
      gnt_en = 1'b1;
      gnt_ch = lock_ch_q;
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        cand = {1'b0, ptr_q} + (CH_W+1)'(i);
        if (cand >= NUM_CH_X) begin
          cand = cand - NUM_CH_X;
        end
        if (elig[cand[CH_W-1:0]]) begin
          gnt_en = 1'b1;
          gnt_ch = cand[CH_W-1:0];
        end
      end
    end
  end

  always_comb begin
    rdy = '0;
    if (i_rst_n && gnt_en && out_free) begin
      rdy[gnt_ch] = 1'b1;
    end
  end

  assign xfer = gnt_en && out_free && bus.i_valid[gnt_ch];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_ch_d = lock_ch_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    o_ch_d    = o_ch_q;
    nxt_ch    = {1'b0, gnt_ch} + (CH_W+1)'(1);
    if (nxt_ch >= NUM_CH_X) begin
      nxt_ch = '0;
    end
    if (xfer) begin
      o_valid_d = 1'b1;
      o_data_d  = bus.i_data[int'(gnt_ch)*DATA_W +: DATA_W];
      o_last_d  = bus.i_last[gnt_ch];
      o_ch_d    = gnt_ch;
      if (state_q == S_IDLE) begin
        ptr_d = nxt_ch[CH_W-1:0];
        if (!bus.i_last[gnt_ch]) begin
          state_d   = S_LOCKED;
          lock_ch_d = gnt_ch;
        end
      end else if (bus.i_last[gnt_ch]) begin
        state_d = S_IDLE;
      end
    end else if (out_free) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      lock_ch_q <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_ch_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_ch_q <= lock_ch_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      o_ch_q    <= o_ch_d;
    end
  end

  assign bus.o_ready = rdy;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_last  = o_last_q;
  assign bus.o_ch    = o_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed and random checks of stream_mux_rr against a packet-level model
module tb_stream_mux_rr;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.NUM_CH(N), .DATA_W(W)) bus();

`ifdef STREAM_MUX_FORCE_SEL_EN
  logic       force_en = 1'b0;
  logic [1:0] force_ch = 2'd0;
`endif

  stream_mux_rr #(.NUM_CH(N), .DATA_W(W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
`ifdef STREAM_MUX_FORCE_SEL_EN
    .i_force    (force_en),
    .i_force_ch (force_ch),
`endif
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: rotation pointer, locked channel (-1 = none), expected output register.
  int         m_ptr;
  int         m_lock;
  logic       m_ov;
  logic [7:0] m_od;
  logic       m_ol;
  int         m_och;
  logic [3:0] tx_mask;
  int         open_ch;
  int         acc55;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_lock  = -1;
    m_ov    = 1'b0;
    m_od    = 8'h00;
    m_ol    = 1'b0;
    m_och   = 0;
    open_ch = -1;
  endtask

  function automatic int model_grant();
    if (m_lock >= 0) return m_lock;
`ifdef STREAM_MUX_FORCE_SEL_EN
    if (force_en) begin
      if (int'(force_ch) < N && bus.i_valid[force_ch]) return int'(force_ch);
      return -1;
    end
`endif
    for (int k = 0; k < N; k++) begin
      if (bus.i_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_ch(input int k, input logic v, input logic [7:0] d, input logic l);
    bus.i_valid[k]       = v;
    bus.i_data[k*W +: W] = d;
    bus.i_last[k]        = l;
  endtask

  // Check the current cycle against the model, advance the model, move to the next falling edge.
  task automatic cycle();
    int         g;
    logic       free;
    logic [3:0] exp_rdy;
    #1;
    g       = model_grant();
    free    = !m_ov || bus.i_ready;
    exp_rdy = (g >= 0 && free) ? 4'(1 << g) : 4'b0000;
    chk("o_ready", 32'(bus.o_ready), 32'(exp_rdy));
    chk("o_valid", 32'(bus.o_valid), 32'(m_ov));
    chk("o_data",  32'(bus.o_data),  32'(m_od));
    chk("o_last",  32'(bus.o_last),  32'(m_ol));
    chk("o_ch",    32'(bus.o_ch),    32'(m_och));
    if (bus.o_valid && bus.i_ready) begin
      if (open_ch >= 0) chk("pkt_contig", 32'(bus.o_ch), 32'(open_ch));
      open_ch = bus.o_last ? -1 : int'(bus.o_ch);
      if (bus.o_data == 8'h55) acc55++;
    end
    tx_mask = 4'b0000;
    if (g >= 0 && free && bus.i_valid[g]) begin
      tx_mask[g] = 1'b1;
      m_ov  = 1'b1;
      m_od  = bus.i_data[g*W +: W];
      m_ol  = bus.i_last[g];
      m_och = g;
      if (m_lock < 0) begin
        m_ptr = (g + 1) % N;
        if (!m_ol) m_lock = g;
      end else if (m_ol) begin
        m_lock = -1;
      end
    end else if (free) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic random_inputs();
    for (int k = 0; k < N; k++) begin
      if (!(bus.i_valid[k] && !tx_mask[k])) begin
        set_ch(k, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) == 0);
      end
    end
    bus.i_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    bus.i_valid = '0;
    bus.i_data  = '0;
    bus.i_last  = '0;
    bus.i_ready = 1'b1;
    acc55       = 0;
    tx_mask     = 4'b1111;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst0_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst0_o_data",  32'(bus.o_data),  32'd0);
    chk("rst0_o_ch",    32'(bus.o_ch),    32'd0);
    chk("rst0_o_ready", 32'(bus.o_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin over single-beat packets
    for (int k = 0; k < N; k++) set_ch(k, 1'b1, 8'(8'h10 + k), 1'b1);
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("rr_och",   32'(bus.o_ch),    32'(c % N));
      chk("rr_valid", 32'(bus.o_valid), 32'd1);
    end
    bus.i_valid = '0;
    cycle();

    // Packet lock: ch0 single beat moves ptr to 1, then ch1 3-beat packet against ch2
    set_ch(0, 1'b1, 8'h30, 1'b1);
    cycle();
    set_ch(0, 1'b0, 8'h30, 1'b1);
    set_ch(1, 1'b1, 8'hA1, 1'b0);
    set_ch(2, 1'b1, 8'hB2, 1'b1);
    #1 chk("lock_rdy_a1", 32'(bus.o_ready), 32'h2);
    cycle();
    chk("lock_a1", 32'(bus.o_data), 32'hA1);
    set_ch(1, 1'b1, 8'hA2, 1'b0);
    #1 chk("lock_rdy_a2", 32'(bus.o_ready), 32'h2);
    cycle();
    chk("lock_a2", 32'(bus.o_data), 32'hA2);
    set_ch(1, 1'b1, 8'hA3, 1'b1);
    cycle();
    chk("lock_a3", 32'(bus.o_data), 32'hA3);
    chk("lock_a3_ch", 32'(bus.o_ch), 32'd1);
    set_ch(1, 1'b0, 8'hA3, 1'b1);
    cycle();
    chk("lock_b2", 32'(bus.o_data), 32'hB2);
    chk("lock_b2_ch", 32'(bus.o_ch), 32'd2);
    bus.i_valid = '0;
    cycle();

    // Backpressure holding 0x55
    set_ch(3, 1'b1, 8'h55, 1'b1);
    cycle();
    chk("bp_load", 32'(bus.o_data), 32'h55);
    set_ch(3, 1'b0, 8'h55, 1'b1);
    for (int k = 0; k < 3; k++) set_ch(k, 1'b1, 8'(8'h60 + k), 1'b1);
    bus.i_ready = 1'b0;
    repeat (3) begin
      #1 chk("bp_rdy", 32'(bus.o_ready), 32'd0);
      cycle();
      chk("bp_hold", 32'(bus.o_data), 32'h55);
    end
    bus.i_ready = 1'b1;
    cycle();
    chk("bp_reload", 32'(bus.o_data), 32'h60);
    bus.i_valid = '0;
    cycle();
    chk("bp_once", 32'(acc55), 32'd1);

    // Lock holds across a producer gap
    set_ch(0, 1'b1, 8'hC1, 1'b0);
    cycle();
    set_ch(0, 1'b0, 8'hC1, 1'b0);
    set_ch(3, 1'b1, 8'hD3, 1'b1);
    repeat (2) begin
      #1 chk("gap_rdy3", 32'(bus.o_ready[3]), 32'd0);
      cycle();
    end
    set_ch(0, 1'b1, 8'hC2, 1'b1);
    cycle();
    chk("gap_c2_ch", 32'(bus.o_ch), 32'd0);
    set_ch(0, 1'b0, 8'hC2, 1'b1);
    cycle();
    chk("gap_d3_ch", 32'(bus.o_ch), 32'd3);
    bus.i_valid = '0;
    cycle();

`ifdef STREAM_MUX_FORCE_SEL_EN
    for (int k = 0; k < N; k++) set_ch(k, 1'b1, 8'(8'h70 + k), 1'b1);
    force_en = 1'b1;
    force_ch = 2'd2;
    #1 chk("force_rdy", 32'(bus.o_ready), 32'h4);
    cycle();
    chk("force_ch", 32'(bus.o_ch), 32'd2);
    force_en = 1'b0;
    cycle();
    chk("force_ptr", 32'(bus.o_ch), 32'd3);
    bus.i_valid = '0;
    cycle();
`endif

    // Random traffic
    tx_mask = 4'b1111;
    repeat (400) begin
      random_inputs();
      cycle();
    end

    // Asynchronous reset mid-stream
    bus.i_valid = 4'b1111;
    bus.i_last  = 4'b1111;
    bus.i_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_data",  32'(bus.o_data),  32'd0);
    chk("rst_o_ready", 32'(bus.o_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_ch", 32'(bus.o_ch), 32'd0);
    chk("post_rst_valid", 32'(bus.o_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
